acq_fifo_sched: RTL and testbench
=================================

# acq_fifo_sched

Write-arbiter and read-sequencer for the acquisition sample FIFO (`syn_fifo`). Up to N_CH ADC channel front-ends share the FIFO write port through a round-robin arbiter. Each word is tagged with its channel index. The read side drains the FIFO in fixed-length frames toward the host link with a valid/ready handshake. The block tracks FIFO occupancy itself, because the FIFO exposes only `full` and `empty`.

## Interface
- N_CH, 4: number of channel requesters (2..8).
- DATA_W, 24: sample width.
- CH_W, 2: channel tag width, equal to clog2(N_CH).
- DEPTH, 32: FIFO depth. The usable level is DEPTH-1, matching the FIFO `full` flag.
- FRAME_LEN, 8: words per output frame (1..DEPTH-1).
- RD_LAT, 1: cycles from `fifo_rd_en` to valid `fifo_rdata` (1..3).

Ports:
- clk  in  1  clock, rising edge.
- rst_a  in  1  reset, asynchronous, active-high.
- en  in  1  enables grants and frame starts.
- flush  in  1  level-sensitive. Starts a short frame when level < FRAME_LEN.
- ch_valid  in  N_CH  sample valid per channel.
- ch_data  in  N_CH*DATA_W  samples. Channel i occupies bits [i*DATA_W +: DATA_W].
- ch_ready  out  N_CH  one-hot grant. A transfer occurs when valid and ready are both high.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wdata  out  CH_W+DATA_W  {channel, sample}.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_rdata  in  CH_W+DATA_W  FIFO read data.
- fifo_empty  in  1  FIFO empty flag, used only for the consistency check.
- out_valid, out_ready  out/in  1  output handshake.
- out_data  out  DATA_W  sample.
- out_ch  out  CH_W  channel tag.
- out_sof, out_eof  out  1  first / last word of frame, qualified by out_valid.
- level  out  clog2(DEPTH)+1  tracked occupancy.
- err  out  1  sticky. Set if `fifo_empty`=1 when a read is issued.

## Operation
- Write arbiter:
  - Each cycle, when en=1 and level < DEPTH-1, ch_ready is one-hot on the first channel with ch_valid=1, searching from rr_ptr upward and wrapping.
  - On a transfer: fifo_wr_en=1, fifo_wdata={i, ch_data[i]}, rr_ptr ← i+1 mod N_CH.
  - With no valid channel, or level at DEPTH-1, ch_ready=0 and rr_ptr holds.
  - ch_ready and fifo_wr_en are combinational from registered level/rr_ptr and from ch_valid.
- Level counter:
  - +1 on write only, −1 on read only, unchanged on simultaneous write and read.
  - Saturates: never exceeds DEPTH-1, never drops below 0.
- Read FSM:
  - IDLE → REQ when level ≥ FRAME_LEN and en=1. Frame length is FRAME_LEN.
  - IDLE → REQ when flush=1 and level > 0. Frame length is min(level, FRAME_LEN), latched at entry.
  - REQ: fifo_rd_en=1 for exactly one cycle, then → WAIT.
  - WAIT: count RD_LAT cycles, capture fifo_rdata into the out_* registers, set out_valid, then → HOLD.
  - HOLD: out_valid stays high and out_* stay stable until out_ready=1. Then:
    - → REQ if words remain in the frame;
    - → IDLE otherwise.
- Framing:
  - out_sof=1 on word 0 of each frame.
  - out_eof=1 on word len-1. For len=1, both are set on the same word.
  - Word counter width is clog2(FRAME_LEN)+1.
- en deasserted mid-frame: the current frame completes; no new frame starts.
- flush during a frame is ignored until IDLE.

## Timing
- Reset values:
  - ch_ready=0, fifo_wr_en=0, fifo_rd_en=0;
  - out_valid=0, out_data=0, out_ch=0, out_sof=0, out_eof=0;
  - level=0, err=0, rr_ptr=0, FSM=IDLE.
- Write: a sample is accepted in the same cycle as the grant; level updates on the next edge.
- Read latency from entering REQ to out_valid is RD_LAT+1 cycles.
- Best-case frame rate is one word per RD_LAT+2 cycles when out_ready is held at 1.
- Reset mid-frame: immediate abort. No eof is emitted, and partial frame state is discarded.
- The FIFO must be reset together with this block from the same rst_a.

## Structure
- Package `acq_pkg`: state enum (IDLE, REQ, WAIT, HOLD) and a clog2 function.
- Sub-module `rr_arbiter` (N_CH): inputs req, en, ptr; outputs one-hot grant and the next pointer value.
- Top level: level counter, read FSM, output registers. Target size is roughly 200 lines of RTL.

## Test plan
- Reset, then all 4 channels valid continuously, out_ready=1, FRAME_LEN=8:
  - grants cycle 0,1,2,3,0…;
  - the first frame starts when level reaches 8;
  - out_ch sequence is 0,1,2,3,0,1,2,3;
  - sof is on word 0 and eof on word 7.
- Output stalled (out_ready=0), channels always valid:
  - level climbs to 31 and holds;
  - ch_ready=0 at 31, no fifo_wr_en, no overflow.
- Level 3, flush pulse while IDLE:
  - a 3-word frame is emitted, with eof on word 2;
  - level returns to 0.
- Simultaneous write and read in the same cycle: level unchanged. Checked across 100 random cycles against a reference counter.
- rst_a asserted in HOLD with out_valid=1:
  - all outputs go to 0 immediately;
  - the next frame begins fresh with sof.
- fifo_empty forced to 1 while a read is issued: err=1 and stays set until reset.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared types and helpers for the acquisition FIFO scheduler.
// No logic; no latency.
// No flow control.
package acq_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} rd_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/acq_fifo_sched_rr_arbiter.sv
// Round-robin one-hot grant among requesters, starting the search at ptr.
// Latency: purely combinational.
// Backpressure: en low forces an all-zero grant; next_ptr then holds at ptr.
module rr_arbiter
    import acq_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic            en,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] next_ptr
);

    logic            found;
    logic [CH_W-1:0] idx;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = CH_W'((int'(ptr) + k) % N_CH);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = (idx == CH_W'(N_CH - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/acq_fifo_sched.sv
// Arbitrates channel samples into the sample FIFO and drains it in tagged frames.
// Latency: write accepted in the grant cycle; read data on out_* RD_LAT+1 cycles after REQ.
// Backpressure: writes stop at level DEPTH-1; out_* held stable until out_ready.
module acq_fifo_sched
    import acq_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 24,
    parameter int CH_W      = clog2(N_CH),
    parameter int DEPTH     = 32,
    parameter int FRAME_LEN = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                      clk,
    input  logic                      rst_a,
    input  logic                      en,
    input  logic                      flush,
    input  logic [N_CH-1:0]           ch_valid,
    input  logic [N_CH*DATA_W-1:0]    ch_data,
    output logic [N_CH-1:0]           ch_ready,
    output logic                      fifo_wr_en,
    output logic [CH_W+DATA_W-1:0]    fifo_wdata,
    output logic                      fifo_rd_en,
    input  logic [CH_W+DATA_W-1:0]    fifo_rdata,
    input  logic                      fifo_empty,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [CH_W-1:0]           out_ch,
    output logic                      out_sof,
    output logic                      out_eof,
    output logic [clog2(DEPTH):0]     level,
    output logic                      err
);

    localparam int LVL_W = clog2(DEPTH) + 1;
    localparam int WC_W  = clog2(FRAME_LEN) + 1;
    localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FRAME = LVL_W'(FRAME_LEN);

    logic [CH_W-1:0]   rr_ptr, rr_next;
    logic [N_CH-1:0]   grant;
    logic              wr_ok;
    logic [DATA_W-1:0] wr_data;
    logic [CH_W-1:0]   wr_ch;
    rd_state_t         state;
    logic [WC_W-1:0]   frame_len, word_idx;
    logic [1:0]        lat_cnt;

    // Grants are suppressed while reset is asserted so ch_ready reads 0 in reset.
    assign wr_ok = en && !rst_a && (level < LVL_MAX);

    rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
        .req      (ch_valid),
        .en       (wr_ok),
        .ptr      (rr_ptr),
        .grant    (grant),
        .next_ptr (rr_next)
    );

    assign ch_ready   = grant;
    assign fifo_wr_en = |grant;
    assign fifo_rd_en = (state == REQ);

    always_comb begin
        wr_data = '0;
        wr_ch   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                wr_data = ch_data[i*DATA_W +: DATA_W];
                wr_ch   = CH_W'(i);
            end
        end
    end

    assign fifo_wdata = {wr_ch, wr_data};

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            rr_ptr <= '0;
            level  <= '0;
        end else begin
            if (fifo_wr_en) begin
                rr_ptr <= rr_next;
            end
            case ({fifo_wr_en, fifo_rd_en})
                2'b10: if (level < LVL_MAX) level <= level + 1'b1;
                2'b01: if (level != '0)     level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state     <= IDLE;
            frame_len <= '0;
            word_idx  <= '0;
            lat_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (fifo_rd_en && fifo_empty) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (en && level >= LVL_FRAME) begin
                        frame_len <= WC_W'(FRAME_LEN);
                        word_idx  <= '0;
                        state     <= REQ;
                    end else if (flush && level != '0) begin
                        // Short frame length is frozen here; later writes don't extend it.
                        frame_len <= (level < LVL_FRAME) ? WC_W'(level) : WC_W'(FRAME_LEN);
                        word_idx  <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    lat_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 2'(RD_LAT - 1)) begin
                        out_data  <= fifo_rdata[DATA_W-1:0];
                        out_ch    <= fifo_rdata[DATA_W +: CH_W];
                        out_sof   <= (word_idx == '0);
                        out_eof   <= (word_idx == frame_len - 1'b1);
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        word_idx  <= word_idx + 1'b1;
                        state     <= out_eof ? IDLE : REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acq_fifo_sched.sv
// Directed bench for acq_fifo_sched with a behavioural sample FIFO (registered read, full at DEPTH-1).
module tb_acq_fifo_sched;
    import acq_pkg::*;

    localparam int N_CH = 4, DATA_W = 24, CH_W = 2, DEPTH = 32, FRAME_LEN = 8, RD_LAT = 1;

    logic                   clk = 1'b0;
    logic                   rst_a = 1'b1;
    logic                   en = 1'b0, flush = 1'b0, out_ready = 1'b0, force_empty = 1'b0;
    logic [N_CH-1:0]        ch_valid = '0;
    logic [N_CH*DATA_W-1:0] ch_data = '0;
    logic [N_CH-1:0]        ch_ready;
    logic                   fifo_wr_en, fifo_rd_en, fifo_empty;
    logic [CH_W+DATA_W-1:0] fifo_wdata, fifo_rdata;
    logic                   out_valid, out_sof, out_eof, err;
    logic [DATA_W-1:0]      out_data;
    logic [CH_W-1:0]        out_ch;
    logic [5:0]             level;

    always #5 clk = ~clk;

    acq_fifo_sched #(.N_CH(N_CH), .DATA_W(DATA_W), .CH_W(CH_W), .DEPTH(DEPTH),
                     .FRAME_LEN(FRAME_LEN), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_a(rst_a), .en(en), .flush(flush), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ready(ch_ready), .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .fifo_rd_en(fifo_rd_en),
        .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .out_sof(out_sof), .out_eof(out_eof), .level(level), .err(err)
    );

    // Sample FIFO model
    logic [CH_W+DATA_W-1:0] mem [DEPTH];
    logic [4:0]             wp, rp;
    int                     cnt;
    logic                   ovf;

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            wp <= '0; rp <= '0; cnt <= 0; ovf <= 1'b0; fifo_rdata <= '0;
        end else begin
            if (fifo_wr_en) begin
                if (cnt >= DEPTH - 1) ovf <= 1'b1;
                else begin mem[wp] <= fifo_wdata; wp <= wp + 1'b1; end
            end
            if (fifo_rd_en && cnt > 0) begin
                fifo_rdata <= mem[rp];
                rp <= rp + 1'b1;
            end
            cnt <= cnt + ((fifo_wr_en && cnt < DEPTH - 1) ? 1 : 0) - ((fifo_rd_en && cnt > 0) ? 1 : 0);
        end
    end

    assign fifo_empty = (cnt == 0) || force_empty;

    typedef struct { logic [CH_W-1:0] ch; logic [DATA_W-1:0] data; logic sof; logic eof; int t; } word_t;
    typedef struct { int word; logic [CH_W-1:0] ch; logic [DATA_W-1:0] data; logic sof; logic eof; } vec_t;

    word_t obs[$];
    int    gq[$];
    vec_t  tbl[12];
    int    seq[N_CH];
    int    checks = 0, failures = 0;
    int    cyc = 0, rd_cnt = 0, first_rd_lvl = -1, max_lvl = 0;
    logic  last_wr, last_rd;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < N_CH; i++)
            ch_data[i*DATA_W +: DATA_W] = DATA_W'((i + 1) * 32'h100000 + seq[i]);
    endtask

    task automatic start_reset();
        rst_a = 1'b1;
        en = 1'b0; flush = 1'b0; ch_valid = '0; out_ready = 1'b0; force_empty = 1'b0;
        for (int i = 0; i < N_CH; i++) seq[i] = 0;
        drive_data();
        obs.delete(); gq.delete();
        rd_cnt = 0; first_rd_lvl = -1; max_lvl = 0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
    endtask

    task automatic tick();
        int    gi;
        word_t w;
        gi = -1;
        @(negedge clk);
        cyc++;
        if (out_valid && out_ready) begin
            w.ch = out_ch; w.data = out_data; w.sof = out_sof; w.eof = out_eof; w.t = cyc;
            obs.push_back(w);
        end
        for (int i = 0; i < N_CH; i++) if (ch_ready[i] && ch_valid[i]) gi = i;
        if (gi >= 0) gq.push_back(gi);
        if (fifo_rd_en) begin
            rd_cnt++;
            if (first_rd_lvl < 0) first_rd_lvl = int'(level);
        end
        if (int'(level) > max_lvl) max_lvl = int'(level);
        last_wr = fifo_wr_en;
        last_rd = fifo_rd_en;
        @(posedge clk);
        #1;
        if (gi >= 0) seq[gi]++;
        drive_data();
    endtask

    initial begin
        int n, ref_lvl, sim_cnt;

        tbl[0]  = '{0, 2'd0, 24'h100000, 1'b1, 1'b0};
        tbl[1]  = '{1, 2'd1, 24'h200000, 1'b0, 1'b0};
        tbl[2]  = '{2, 2'd2, 24'h300000, 1'b0, 1'b0};
        tbl[3]  = '{3, 2'd3, 24'h400000, 1'b0, 1'b0};
        tbl[4]  = '{4, 2'd0, 24'h100001, 1'b0, 1'b0};
        tbl[5]  = '{5, 2'd1, 24'h200001, 1'b0, 1'b0};
        tbl[6]  = '{6, 2'd2, 24'h300001, 1'b0, 1'b0};
        tbl[7]  = '{7, 2'd3, 24'h400001, 1'b0, 1'b1};
        tbl[8]  = '{8, 2'd0, 24'h100002, 1'b1, 1'b0};
        tbl[9]  = '{0, 2'd1, 24'h200000, 1'b1, 1'b0};
        tbl[10] = '{1, 2'd1, 24'h200001, 1'b0, 1'b0};
        tbl[11] = '{2, 2'd1, 24'h200002, 1'b0, 1'b1};

        // Reset values, with requests pending during reset
        start_reset();
        en = 1'b1; ch_valid = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ch_ready", ch_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_sof", out_sof, 0);
        chk("rst_eof", out_eof, 0);
        chk("rst_level", level, 0);
        chk("rst_err", err, 0);

        // All channels streaming, output always ready
        @(posedge clk);
        #1 rst_a = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (obs.size() < 9 && n < 300) begin tick(); n++; end
        chk("t1_enough_words", obs.size() >= 9, 1);
        for (int i = 0; i < 8; i++) chk($sformatf("t1_grant%0d", i), gq[i], i % 4);
        chk("t1_level_at_first_read", first_rd_lvl, FRAME_LEN + 1);
        if (obs.size() >= 9) begin
            for (int i = 0; i < 9; i++) begin
                chk($sformatf("t1_ch_w%0d", i),   obs[tbl[i].word].ch,   tbl[i].ch);
                chk($sformatf("t1_data_w%0d", i), obs[tbl[i].word].data, tbl[i].data);
                chk($sformatf("t1_sof_w%0d", i),  obs[tbl[i].word].sof,  tbl[i].sof);
                chk($sformatf("t1_eof_w%0d", i),  obs[tbl[i].word].eof,  tbl[i].eof);
            end
            chk("t1_word_period", obs[2].t - obs[1].t, RD_LAT + 2);
        end

        // Output stalled: level saturates at DEPTH-1
        start_reset();
        release_reset();
        en = 1'b1; ch_valid = 4'hF;
        repeat (80) tick();
        chk("t2_level_full", level, DEPTH - 1);
        chk("t2_ch_ready_full", ch_ready, 0);
        chk("t2_wr_en_full", fifo_wr_en, 0);
        chk("t2_max_level", max_lvl, DEPTH - 1);
        chk("t2_no_overflow", ovf, 0);
        chk("t2_fifo_count", cnt, DEPTH - 1);
        chk("t2_held_valid", out_valid, 1);

        // Flush a 3-word short frame
        start_reset();
        release_reset();
        en = 1'b1; out_ready = 1'b1; ch_valid = 4'b0010;
        repeat (3) tick();
        ch_valid = '0;
        tick();
        chk("t3_level_before_flush", level, 3);
        chk("t3_idle_before_flush", rd_cnt, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n = 0;
        while (obs.size() < 3 && n < 40) begin tick(); n++; end
        repeat (5) tick();
        chk("t3_word_count", obs.size(), 3);
        if (obs.size() >= 3) begin
            for (int i = 9; i < 12; i++) begin
                chk($sformatf("t3_ch_w%0d", tbl[i].word),   obs[tbl[i].word].ch,   tbl[i].ch);
                chk($sformatf("t3_data_w%0d", tbl[i].word), obs[tbl[i].word].data, tbl[i].data);
                chk($sformatf("t3_sof_w%0d", tbl[i].word),  obs[tbl[i].word].sof,  tbl[i].sof);
                chk($sformatf("t3_eof_w%0d", tbl[i].word),  obs[tbl[i].word].eof,  tbl[i].eof);
            end
        end
        chk("t3_level_after", level, 0);
        chk("t3_reads", rd_cnt, 3);

        // Random traffic: level tracks a reference counter
        start_reset();
        release_reset();
        en = 1'b1;
        ref_lvl = 0; sim_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            ch_valid  = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (last_wr && !last_rd) ref_lvl++;
            else if (last_rd && !last_wr) ref_lvl--;
            else if (last_rd && last_wr) sim_cnt++;
            chk($sformatf("t4_level_c%0d", i), level, ref_lvl);
        end
        chk("t4_saw_simultaneous", sim_cnt > 0, 1);
        chk("t4_level_vs_fifo", level, cnt);
        chk("t4_err_clear", err, 0);

        // Reset while holding a word
        start_reset();
        release_reset();
        en = 1'b1; ch_valid = 4'hF;
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        chk("t5_reached_hold", out_valid, 1);
        start_reset();
        en = 1'b1; ch_valid = 4'hF;
        #1;
        chk("t5_valid_cleared", out_valid, 0);
        chk("t5_data_cleared", out_data, 0);
        chk("t5_ch_cleared", out_ch, 0);
        chk("t5_sof_cleared", out_sof, 0);
        chk("t5_eof_cleared", out_eof, 0);
        chk("t5_level_cleared", level, 0);
        chk("t5_ready_cleared", ch_ready, 0);
        release_reset();
        out_ready = 1'b1;
        n = 0;
        while (obs.size() < 1 && n < 40) begin tick(); n++; end
        chk("t5_new_word", obs.size() >= 1, 1);
        if (obs.size() >= 1) begin
            chk("t5_new_sof", obs[0].sof, 1);
            chk("t5_new_ch", obs[0].ch, 0);
            chk("t5_new_data", obs[0].data, 24'h100000);
        end

        // Read issued against an empty flag: sticky err
        start_reset();
        release_reset();
        en = 1'b1; out_ready = 1'b1; ch_valid = 4'b0001;
        repeat (2) tick();
        ch_valid = '0;
        chk("t6_err_before", err, 0);
        force_empty = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        n = 0;
        while (rd_cnt == 0 && n < 10) begin tick(); n++; end
        chk("t6_err_set", err, 1);
        force_empty = 1'b0;
        repeat (10) tick();
        chk("t6_err_sticky", err, 1);
        start_reset();
        #1;
        chk("t6_err_reset", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
